// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// mux/ALU-class codes and the packed control vector.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Moore output decode: control vector from the current state, with the
// memory handshake qualifying the PC/IR write during fetch.
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// retired-instruction counter; outputs decode directly from the state.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] retired_q;
    logic             retire_c;
    ctrl_t            ctrl_d;
    ctrl_t            ctrl_g;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_n;
            if (retire_c) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_n = S_R_EXEC;
                    OP_LW, OP_SW: state_n = S_MEM_ADDR;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_J:         state_n = S_JUMP;
                    OP_ADDI:      state_n = S_ADDI_EXEC;
                    default:      state_n = S_TRAP;
                endcase
            end
            // Opcode is held in the IR, so only lw/sw can reach here.
            S_MEM_ADDR:  state_n = (opcode == OP_LW) ? S_MEM_READ :
                                   (opcode == OP_SW) ? S_MEM_WRITE : S_TRAP;
            S_MEM_READ:  if (mem_ready) state_n = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_n = S_FETCH;
            S_R_EXEC:    state_n = S_R_WB;
            S_ADDI_EXEC: state_n = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_n = S_FETCH;
            S_TRAP:      state_n = S_TRAP;
            default:     state_n = S_TRAP;
        endcase
    end

    always_comb begin
        retire_c = 1'b0;
        case (state_q)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire_c = 1'b1;
            S_MEM_WRITE: retire_c = mem_ready;
            default:     retire_c = 1'b0;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_d)
    );

    // Reset blanks every enable so nothing is written during the reset cycle.
    assign ctrl_g = rst ? '0 : ctrl_d;

    assign PCWrite     = ctrl_g.pc_write;
    assign PCWriteCond = ctrl_g.pc_write_cond;
    assign IorD        = ctrl_g.i_or_d;
    assign MemRead     = ctrl_g.mem_read;
    assign MemWrite    = ctrl_g.mem_write;
    assign IRWrite     = ctrl_g.ir_write;
    assign MemtoReg    = ctrl_g.mem_to_reg;
    assign RegWrite    = ctrl_g.reg_write;
    assign RegDst      = ctrl_g.reg_dst;
    assign ALUSrcA     = ctrl_g.alu_src_a;
    assign PCSource    = ctrl_g.pc_source;
    assign ALUSrcB     = ctrl_g.alu_src_b;
    assign ALUOp       = ctrl_g.alu_op;
    assign state       = state_q;
    assign illegal     = !rst && (state_q == S_TRAP);
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues the expected
// state/counter per cycle, the monitor checks every output on the falling edge.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 3;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]       PCSource, ALUSrcB, ALUOp;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    typedef struct {
        logic [3:0]       st;
        logic [CNT_W-1:0] ret;
        logic             r;
        logic             mr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    // Bit order: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
    // RegWrite,RegDst,ALUSrcA,PCSource[1:0],ALUSrcB[1:0],ALUOp[1:0].
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
        case (st)
            4'd0:  return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b00, 2'b01, 2'b00};
            4'd1:  return {10'b0, 2'b00, 2'b11, 2'b00};
            4'd2:  return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            4'd3:  return {2'b00, 1'b1, 1'b1, 6'b0, 6'b0};
            4'd4:  return {6'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b0};
            4'd5:  return {2'b00, 1'b1, 1'b0, 1'b1, 5'b0, 6'b0};
            4'd6:  return {9'b0, 1'b1, 2'b00, 2'b00, 2'b10};
            4'd7:  return {7'b0, 1'b1, 1'b1, 1'b0, 6'b0};
            4'd8:  return {1'b0, 1'b1, 7'b0, 1'b1, 2'b01, 2'b00, 2'b01};
            4'd9:  return {1'b1, 9'b0, 2'b10, 2'b00, 2'b00};
            4'd10: return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            4'd11: return {7'b0, 1'b1, 1'b0, 1'b0, 6'b0};
            default: return 16'h0000;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [15:0] act;
        logic [15:0] want;
        logic        want_ill;
        exp_t        e;
        cycle++;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp};
            want = e.r ? 16'h0000 : exp_ctrl(e.st, e.mr);
            want_ill = !e.r && (e.st == 4'd12);
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state cyc=%0d got=%0d exp=%0d", cycle, state, e.st);
            end
            checks++;
            if (retired !== e.ret) begin
                errors++;
                $display("FAIL retired cyc=%0d got=%0d exp=%0d", cycle, retired, e.ret);
            end
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL ctrl cyc=%0d st=%0d got=%b exp=%b", cycle, e.st, act, want);
            end
            checks++;
            if (illegal !== want_ill) begin
                errors++;
                $display("FAIL illegal cyc=%0d got=%b exp=%b", cycle, illegal, want_ill);
            end
        end
    end

    task automatic step(input logic r, input logic mr, input logic [5:0] op,
                        input logic [3:0] st, input int ret);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = mr;
        opcode    = op;
        e.st  = st;
        e.ret = CNT_W'(ret);
        e.r   = r;
        e.mr  = mr;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = OP_R;
        @(posedge clk);
        // Reset held with mem_ready high: all enables must stay low.
        step(1, 1, OP_R, 4'd0, 0);

        // add
        step(0, 1, OP_R, 4'd0, 0);
        step(0, 1, OP_R, 4'd1, 0);
        step(0, 1, OP_R, 4'd6, 0);
        step(0, 1, OP_R, 4'd7, 0);

        // lw with fetch and read waits
        step(0, 0, OP_LW, 4'd0, 1);
        step(0, 0, OP_LW, 4'd0, 1);
        step(0, 1, OP_LW, 4'd0, 1);
        step(0, 1, OP_LW, 4'd1, 1);
        step(0, 1, OP_LW, 4'd2, 1);
        step(0, 0, OP_LW, 4'd3, 1);
        step(0, 0, OP_LW, 4'd3, 1);
        step(0, 0, OP_LW, 4'd3, 1);
        step(0, 1, OP_LW, 4'd3, 1);
        step(0, 1, OP_LW, 4'd4, 1);

        // sw
        step(0, 1, OP_SW, 4'd0, 2);
        step(0, 1, OP_SW, 4'd1, 2);
        step(0, 1, OP_SW, 4'd2, 2);
        step(0, 1, OP_SW, 4'd5, 2);

        // beq then j
        step(0, 1, OP_BEQ, 4'd0, 3);
        step(0, 1, OP_BEQ, 4'd1, 3);
        step(0, 1, OP_BEQ, 4'd8, 3);
        step(0, 1, OP_J,   4'd0, 4);
        step(0, 1, OP_J,   4'd1, 4);
        step(0, 1, OP_J,   4'd9, 4);

        // addi
        step(0, 1, OP_ADDI, 4'd0, 5);
        step(0, 1, OP_ADDI, 4'd1, 5);
        step(0, 1, OP_ADDI, 4'd10, 5);
        step(0, 1, OP_ADDI, 4'd11, 5);

        // illegal opcode: trap held, then cleared by reset
        step(0, 1, OP_BAD, 4'd0, 6);
        step(0, 1, OP_BAD, 4'd1, 6);
        for (int i = 0; i < 10; i++) step(0, 1, OP_BAD, 4'd12, 6);
        step(1, 1, OP_BAD, 4'd12, 6);

        // sw interrupted by reset while waiting on memory
        step(0, 1, OP_SW, 4'd0, 0);
        step(0, 1, OP_SW, 4'd1, 0);
        step(0, 1, OP_SW, 4'd2, 0);
        step(0, 0, OP_SW, 4'd5, 0);
        step(1, 0, OP_SW, 4'd5, 0);

        // eight jumps: counter reaches 2^CNT_W-1 then wraps to 0
        for (int i = 0; i < 8; i++) begin
            step(0, 1, OP_J, 4'd0, i);
            step(0, 1, OP_J, 4'd1, i);
            step(0, 1, OP_J, 4'd9, i);
        end
        step(0, 0, OP_J, 4'd0, 0);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 SHALL have port mem_ready  input  1  memory handshake; the current access completes in a cycle where it is high.
REQ-006 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath enables and mux selects.
REQ-007 SHALL have outputs PCSource, ALUSrcB, ALUOp  output  2 each  PC mux, ALU operand-B mux and ALU-control class.
REQ-008 SHALL have port state  output  4  current FSM state encoding, for debug.
REQ-009 SHALL have port illegal  output  1  high while in TRAP.
REQ-010 SHALL have port retired  output  CNT_W  count of completed instructions.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=12.
REQ-012 SHALL define these transitions: FETCH->DECODE when mem_ready=1; FETCH stays in FETCH otherwise.
REQ-013 SHALL leave DECODE by opcode: 000000->R_EXEC; 100011 or 101011->MEM_ADDR; 000100->BRANCH; 000010->JUMP; 001000->ADDI_EXEC; any other->TRAP.
REQ-014 SHALL leave MEM_ADDR by opcode: 100011->MEM_READ; 101011->MEM_WRITE.
REQ-015 SHALL make MEM_READ->MEM_WB and MEM_WRITE->FETCH only when mem_ready=1, and otherwise hold the state.
REQ-016 SHALL make MEM_WB, R_WB, BRANCH, JUMP and ADDI_WB go to FETCH, R_EXEC go to R_WB, and ADDI_EXEC go to ADDI_WB.
REQ-017 SHALL hold TRAP until rst.
REQ-018 SHALL drive these outputs in FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready, so the PC advances exactly once per fetch.
REQ-019 SHALL drive these outputs in DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, giving the branch target precompute.
REQ-020 SHALL drive these outputs in MEM_ADDR and ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-021 SHALL drive these outputs in MEM_READ: MemRead=1, IorD=1; and in MEM_WRITE: MemWrite=1, IorD=1, with the outputs held steady through wait cycles.
REQ-022 SHALL drive these outputs in MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-023 SHALL drive these outputs in R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; and in R_WB: RegWrite=1, RegDst=1, MemtoReg=0.
REQ-024 SHALL drive these outputs in ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-025 SHALL drive these outputs in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-026 SHALL drive these outputs in JUMP: PCWrite=1, PCSource=10.
REQ-027 SHALL drive 0 on every output not listed for a state; in TRAP all control outputs are 0 and illegal=1.
REQ-028 SHALL increment retired by 1 on each cycle that leaves MEM_WB, R_WB, BRANCH, JUMP or ADDI_WB, and on each MEM_WRITE cycle with mem_ready=1; it wraps modulo 2^CNT_W without a flag.
REQ-029 SHALL give control outputs no registered latency: they decode combinationally from the state register and, in FETCH/MEM_READ/MEM_WRITE, from mem_ready.

Reset
REQ-030 SHALL, on a clk edge with rst=1, set state=FETCH and retired=0, including when rst arrives mid-instruction or mid-wait; no partial write survives.
REQ-031 SHALL force all control outputs and illegal to 0 while rst=1; the first cycle after rst deasserts is FETCH.

Structure
REQ-032 SHALL place the state encodings, the opcode constants (R, LW, SW, BEQ, J, ADDI) and the ALUOp/PCSource/ALUSrcB codes in the shared package mips_ctrl_pkg.
REQ-033 SHALL split the output decode into one sub-module, multicycle_ctrl_decode (state, mem_ready in; control vector out); next-state logic and the counter remain in multicycle_control.

Verification
REQ-034 SHALL cover: add (opcode 000000), mem_ready=1 -> states 0,1,6,7,0; RegWrite=1,RegDst=1 only in state 7; retired 0->1.
REQ-035 SHALL cover: lw (100011) with mem_ready low 2 cycles in FETCH and 3 in MEM_READ -> PCWrite/IRWrite pulse exactly once; state sequence 0,0,0,1,2,3,3,3,3,4,0; retired +1.
REQ-036 SHALL cover: sw (101011), mem_ready=1 -> 0,1,2,5,0; MemWrite=1,IorD=1 in state 5; RegWrite never 1.
REQ-037 SHALL cover: beq (000100) then j (000010) -> state 8 shows PCWriteCond=1,PCSource=01,ALUOp=01; state 9 shows PCWrite=1,PCSource=10; retired +2.
REQ-038 SHALL cover: opcode 111111 -> TRAP after DECODE, illegal=1 held 10 cycles; then rst=1 for 1 cycle -> state=0, retired=0, illegal=0.
REQ-039 SHALL cover: rst asserted in MEM_WRITE while mem_ready=0 -> next cycle state=0, MemWrite=0; counter starting at 2^CNT_W-1 wraps to 0 on the next retire.
